brch_chkpt_tbl: RTL and testbench

Parametrised in-order branch checkpoint table for the dispatch and commit path. Up to DISP_W instructions per cycle can allocate an entry each. Every unresolved branch gets one entry holding its ROB index and its rename/position pointer. On commit the oldest entry is freed. On a mispredict the matching entry and all younger entries are discarded, and a registered flush with the recovery position is raised.

---
 rtl/brch_chkpt_tbl_pkg.sv | 16 +
 rtl/brch_chkpt_tbl_if.sv | 54 +++++
 rtl/brch_lane_pack.sv | 43 ++++
 rtl/brch_chkpt_tbl.sv | 168 ++++++++++++++++
 tb/tb_brch_chkpt_tbl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/brch_chkpt_tbl_pkg.sv
// Shared defaults and entry layout for the branch checkpoint table.
package brch_pkg;

  localparam int BRCH_NUM_ENT = 8;
  localparam int BRCH_DISP_W  = 4;
  localparam int BRCH_IDX_W   = 6;
  localparam int BRCH_POS_W   = 6;

  // Entry fields are sized by the package defaults; the table's IDX_W/POS_W must match.
  typedef struct packed {
    logic                  vld;
    logic [BRCH_IDX_W-1:0] idx;
    logic [BRCH_POS_W-1:0] pos;
  } brch_ent_t;

endpackage

// File: rtl/brch_chkpt_tbl_if.sv
// Dispatch/commit/mispredict bundle for the branch checkpoint table.
// cmt_err is present only when BRCH_TBL_ERR_CHK_EN is defined.
interface brch_chkpt_tbl_if
  import brch_pkg::*;
#(
  parameter int NUM_ENT = BRCH_NUM_ENT,
  parameter int DISP_W  = BRCH_DISP_W,
  parameter int IDX_W   = BRCH_IDX_W,
  parameter int POS_W   = BRCH_POS_W
);
  localparam int CNT_W = $clog2(NUM_ENT) + 1;

  logic [DISP_W-1:0] inst_vld;
  logic [DISP_W-1:0] inst_brch;
  logic [IDX_W-1:0]  nxt_indx;
  logic [POS_W-1:0]  curr_pos;
  logic [DISP_W-1:0] pr_need_inst;
  logic              cmt_brch;
  logic [IDX_W-1:0]  cmt_brch_indx;
  logic              mis_pred;
  logic [IDX_W-1:0]  brch_mis_indx;
  logic              alloc_stall;
  logic [CNT_W-1:0]  brch_cnt;
  logic              flush;
  logic [POS_W-1:0]  flush_pos;
  logic              flush_miss;

`ifdef BRCH_TBL_ERR_CHK_EN
  logic              cmt_err;

  modport master (
    output inst_vld, inst_brch, nxt_indx, curr_pos, pr_need_inst,
    output cmt_brch, cmt_brch_indx, mis_pred, brch_mis_indx,
    input  alloc_stall, brch_cnt, flush, flush_pos, flush_miss, cmt_err
  );
  modport slave (
    input  inst_vld, inst_brch, nxt_indx, curr_pos, pr_need_inst,
    input  cmt_brch, cmt_brch_indx, mis_pred, brch_mis_indx,
    output alloc_stall, brch_cnt, flush, flush_pos, flush_miss, cmt_err
  );
`else
  modport master (
    output inst_vld, inst_brch, nxt_indx, curr_pos, pr_need_inst,
    output cmt_brch, cmt_brch_indx, mis_pred, brch_mis_indx,
    input  alloc_stall, brch_cnt, flush, flush_pos, flush_miss
  );
  modport slave (
    input  inst_vld, inst_brch, nxt_indx, curr_pos, pr_need_inst,
    input  cmt_brch, cmt_brch_indx, mis_pred, brch_mis_indx,
    output alloc_stall, brch_cnt, flush, flush_pos, flush_miss
  );
`endif

endinterface

// File: rtl/brch_lane_pack.sv
// Per-lane ROB index, position and tail write offset for allocating branch lanes.
// Purely combinational.
module brch_lane_pack #(
  parameter int DISP_W = 4,
  parameter int IDX_W  = 6,
  parameter int POS_W  = 6,
  parameter int OFF_W  = $clog2(DISP_W + 1)
) (
  input  logic [DISP_W-1:0]             inst_vld,
  input  logic [DISP_W-1:0]             inst_brch,
  input  logic [IDX_W-1:0]              nxt_indx,
  input  logic [POS_W-1:0]              curr_pos,
  input  logic [DISP_W-1:0]             pr_need_inst,
  output logic [DISP_W-1:0][IDX_W-1:0]  lane_idx,
  output logic [DISP_W-1:0][POS_W-1:0]  lane_pos,
  output logic [DISP_W-1:0][OFF_W-1:0]  lane_off,
  output logic [DISP_W-1:0]             lane_alloc,
  output logic [OFF_W-1:0]              alloc_cnt
);

  logic [OFF_W-1:0] need_acc;
  logic [OFF_W-1:0] off_acc;

  // Running prefix counts: positions consumed and branches allocated by lower lanes.
  always_comb begin
    need_acc   = '0;
    off_acc    = '0;
    lane_idx   = '0;
    lane_pos   = '0;
    lane_off   = '0;
    lane_alloc = '0;
    for (int k = 0; k < DISP_W; k++) begin
      lane_alloc[k] = inst_vld[k] & inst_brch[k];
      lane_idx[k]   = nxt_indx + IDX_W'(k);
      lane_pos[k]   = curr_pos + POS_W'(need_acc);
      lane_off[k]   = off_acc;
      need_acc      = need_acc + OFF_W'(pr_need_inst[k]);
      off_acc       = off_acc + OFF_W'(lane_alloc[k]);
    end
    alloc_cnt = off_acc;
  end

endmodule

// File: rtl/brch_chkpt_tbl.sv
// In-order branch checkpoint table: circular queue of {ROB idx, position} per unresolved branch.
// Latency: alloc_stall combinational; table update and flush/flush_pos/flush_miss one cycle.
// Backpressure: alloc_stall when branches exceed free slots (all-or-nothing); cmt_err with BRCH_TBL_ERR_CHK_EN.
module brch_chkpt_tbl
  import brch_pkg::*;
#(
  parameter int NUM_ENT = BRCH_NUM_ENT,
  parameter int DISP_W  = BRCH_DISP_W,
  parameter int IDX_W   = BRCH_IDX_W,
  parameter int POS_W   = BRCH_POS_W
) (
  input logic             clk,
  input logic             rst_n,
  brch_chkpt_tbl_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_ENT);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = $clog2(DISP_W + 1);

  logic [DISP_W-1:0][IDX_W-1:0] lane_idx;
  logic [DISP_W-1:0][POS_W-1:0] lane_pos;
  logic [DISP_W-1:0][OFF_W-1:0] lane_off;
  logic [DISP_W-1:0]            lane_alloc;
  logic [OFF_W-1:0]             alloc_cnt;

  brch_lane_pack #(
    .DISP_W (DISP_W),
    .IDX_W  (IDX_W),
    .POS_W  (POS_W),
    .OFF_W  (OFF_W)
  ) u_lane_pack (
    .inst_vld     (bus.inst_vld),
    .inst_brch    (bus.inst_brch),
    .nxt_indx     (bus.nxt_indx),
    .curr_pos     (bus.curr_pos),
    .pr_need_inst (bus.pr_need_inst),
    .lane_idx     (lane_idx),
    .lane_pos     (lane_pos),
    .lane_off     (lane_off),
    .lane_alloc   (lane_alloc),
    .alloc_cnt    (alloc_cnt)
  );

  brch_ent_t        ent_q [NUM_ENT];
  brch_ent_t        ent_d [NUM_ENT];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             flush_miss_q, flush_miss_d;
  logic [POS_W-1:0] flush_pos_q, flush_pos_d;

  logic             do_cmt;
  logic             do_alloc;
  logic             alloc_stall;
  logic [CNT_W-1:0] free_cnt;
  logic             mis_hit;
  logic [PTR_W-1:0] hit_slot;
  logic [PTR_W-1:0] hit_age;
  logic [PTR_W-1:0] scan_slot;

  assign do_cmt      = bus.cmt_brch && (cnt_q != '0);
  assign free_cnt    = CNT_W'(NUM_ENT) - cnt_q;
  assign alloc_stall = !bus.mis_pred && (int'(alloc_cnt) > int'(free_cnt));
  assign do_alloc    = !bus.mis_pred && !alloc_stall;

  // Scan from head so the oldest duplicate index wins.
  always_comb begin
    mis_hit   = 1'b0;
    hit_slot  = '0;
    hit_age   = '0;
    scan_slot = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      scan_slot = head_q + PTR_W'(i);
      if (!mis_hit && ent_q[scan_slot].vld && (ent_q[scan_slot].idx == bus.brch_mis_indx)) begin
        mis_hit  = 1'b1;
        hit_slot = scan_slot;
        hit_age  = PTR_W'(i);
      end
    end
  end

  always_comb begin
    ent_d        = ent_q;
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q;
    flush_d      = bus.mis_pred;
    flush_miss_d = bus.mis_pred && !mis_hit;
    flush_pos_d  = (bus.mis_pred && mis_hit) ? ent_q[hit_slot].pos : '0;

    if (do_cmt) begin
      ent_d[head_q].vld = 1'b0;
      head_d            = head_q + PTR_W'(1);
      cnt_d             = cnt_q - CNT_W'(1);
    end

    if (bus.mis_pred) begin
      if (mis_hit) begin
        for (int i = 0; i < NUM_ENT; i++) begin
          if (i >= int'(hit_age)) ent_d[head_q + PTR_W'(i)].vld = 1'b0;
        end
        // A hit on the head leaves the table empty, so tail must meet the new head.
        if (hit_age == '0) begin
          tail_d = head_d;
          cnt_d  = '0;
        end else begin
          tail_d = hit_slot;
          cnt_d  = CNT_W'(hit_age) - CNT_W'(do_cmt);
        end
      end
    end else if (do_alloc) begin
      for (int k = 0; k < DISP_W; k++) begin
        if (lane_alloc[k]) begin
          ent_d[tail_q + PTR_W'(lane_off[k])] = '{vld: 1'b1, idx: lane_idx[k], pos: lane_pos[k]};
        end
      end
      tail_d = tail_q + PTR_W'(alloc_cnt);
      cnt_d  = cnt_d + CNT_W'(alloc_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENT; i++) ent_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      flush_q      <= 1'b0;
      flush_miss_q <= 1'b0;
      flush_pos_q  <= '0;
    end else begin
      ent_q        <= ent_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      flush_miss_q <= flush_miss_d;
      flush_pos_q  <= flush_pos_d;
    end
  end

  assign bus.alloc_stall = alloc_stall;
  assign bus.brch_cnt    = cnt_q;
  assign bus.flush       = flush_q;
  assign bus.flush_pos   = flush_pos_q;
  assign bus.flush_miss  = flush_miss_q;

`ifdef BRCH_TBL_ERR_CHK_EN
  logic cmt_err_q, cmt_err_d;

  always_comb begin
    cmt_err_d = bus.cmt_brch && ((cnt_q == '0) || (ent_q[head_q].idx != bus.cmt_brch_indx));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cmt_err_q <= 1'b0;
    else        cmt_err_q <= cmt_err_d;
  end

  assign bus.cmt_err = cmt_err_q;
`else
  logic cmt_idx_unused;
  assign cmt_idx_unused = ^bus.cmt_brch_indx;
`endif

endmodule

// File: tb/tb_brch_chkpt_tbl.sv
// Directed plus randomized bench for brch_chkpt_tbl against a queue-based reference model.
module tb_brch_chkpt_tbl;
  import brch_pkg::*;

  localparam int NE = BRCH_NUM_ENT;
  localparam int DW = BRCH_DISP_W;
  localparam int IW = BRCH_IDX_W;
  localparam int PW = BRCH_POS_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  brch_chkpt_tbl_if #(.NUM_ENT(NE), .DISP_W(DW), .IDX_W(IW), .POS_W(PW)) bus ();

  brch_chkpt_tbl #(.NUM_ENT(NE), .DISP_W(DW), .IDX_W(IW), .POS_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int idx;
    int pos;
  } mdl_ent_t;

  mdl_ent_t mq[$];
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int v, input int b, input int nx, input int cp, input int nd,
                       input int c, input int ci, input int m, input int mi);
    bus.inst_vld      = DW'(v);
    bus.inst_brch     = DW'(b);
    bus.nxt_indx      = IW'(nx);
    bus.curr_pos      = PW'(cp);
    bus.pr_need_inst  = DW'(nd);
    bus.cmt_brch      = c[0];
    bus.cmt_brch_indx = IW'(ci);
    bus.mis_pred      = m[0];
    bus.brch_mis_indx = IW'(mi);
  endtask

  // One clock: drive at negedge, check stall, advance the model, check registered outputs.
  task automatic cycle(input int v, input int b, input int nx, input int cp, input int nd,
                       input int c, input int ci, input int m, input int mi);
    mdl_ent_t news[$];
    int fnd, e_pos, orig, mask;
    bit e_stall, e_cerr, cv, mv;
    cv = (c & 1) != 0;
    mv = (m & 1) != 0;
    drive(v, b, nx, cp, nd, c, ci, m, mi);
    for (int k = 0; k < DW; k++) begin
      mask = (1 << k) - 1;
      if (((v >> k) & 1) != 0 && ((b >> k) & 1) != 0)
        news.push_back('{idx: (nx + k) % (1 << IW), pos: (cp + $countones(nd & mask)) % (1 << PW)});
    end
    e_stall = !mv && (news.size() > NE - mq.size());
    #1;
    chk("alloc_stall", 32'(bus.alloc_stall), 32'(e_stall));

    e_cerr = cv && (mq.size() == 0 || mq[0].idx != (ci % (1 << IW)));
    fnd = -1;
    if (mv) begin
      for (int i = 0; i < mq.size(); i++)
        if (fnd < 0 && mq[i].idx == (mi % (1 << IW))) fnd = i;
    end
    e_pos = (fnd >= 0) ? mq[fnd].pos : 0;
    orig = mq.size();
    if (fnd >= 0) while (mq.size() > fnd) mq.pop_back();
    if (cv && orig > 0 && mq.size() > 0) void'(mq.pop_front());
    if (!mv && !e_stall) foreach (news[i]) mq.push_back(news[i]);

    @(posedge clk);
    #1;
    chk("brch_cnt", 32'(bus.brch_cnt), 32'(mq.size()));
    chk("flush", 32'(bus.flush), 32'(mv));
    chk("flush_miss", 32'(bus.flush_miss), 32'(mv && fnd < 0));
    chk("flush_pos", 32'(bus.flush_pos), 32'(e_pos));
`ifdef BRCH_TBL_ERR_CHK_EN
    chk("cmt_err", 32'(bus.cmt_err), 32'(e_cerr));
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(15, 15, 1, 2, 15, 1, 0, 1, 0);
    @(posedge clk);
    #1;
    mq.delete();
    chk("rst_cnt", 32'(bus.brch_cnt), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_flush_pos", 32'(bus.flush_pos), 32'd0);
    chk("rst_flush_miss", 32'(bus.flush_miss), 32'd0);
`ifdef BRCH_TBL_ERR_CHK_EN
    chk("rst_cmt_err", 32'(bus.cmt_err), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int v, b, c, ci, m, mi;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Single branch in lane 2: expect {12, 7}.
    cycle(4'b0100, 4'b0100, 10, 5, 4'b0111, 0, 0, 0, 0);
    chk("t1_cnt", 32'(bus.brch_cnt), 32'd1);
    chk("t1_ent_idx", 32'(dut.ent_q[0].idx), 32'd12);
    chk("t1_ent_pos", 32'(dut.ent_q[0].pos), 32'd7);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 12);
    chk("t1_flush_pos", 32'(bus.flush_pos), 32'd7);

    // Capacity: 6 occupied, 3 lanes stall, 2 lanes fill to 8.
    do_reset();
    cycle(4'hF, 4'hF, 0, 0, 4'hF, 0, 0, 0, 0);
    cycle(4'b0011, 4'b0011, 4, 10, 0, 0, 0, 0, 0);
    drive(4'b0111, 4'b0111, 8, 20, 0, 0, 0, 0, 0);
    #1;
    chk("t2_stall", 32'(bus.alloc_stall), 32'd1);
    @(negedge clk);
    cycle(4'b0111, 4'b0111, 8, 20, 0, 0, 0, 0, 0);
    chk("t2_cnt_held", 32'(bus.brch_cnt), 32'd6);
    cycle(4'b0011, 4'b0011, 8, 20, 0, 0, 0, 0, 0);
    chk("t2_cnt_full", 32'(bus.brch_cnt), 32'd8);
    cycle(4'b0001, 4'b0001, 30, 0, 0, 0, 0, 0, 0);

    // Mispredict in the middle, reuse of freed slot, absent index.
    do_reset();
    cycle(1, 1, 3, 11, 0, 0, 0, 0, 0);
    cycle(1, 1, 7, 21, 0, 0, 0, 0, 0);
    cycle(1, 1, 9, 33, 0, 0, 0, 0, 0);
    cycle(1, 1, 12, 44, 0, 0, 0, 0, 0);
    cycle(4'hF, 4'hF, 50, 0, 0, 0, 0, 1, 7);
    chk("t3_flush", 32'(bus.flush), 32'd1);
    chk("t3_flush_pos", 32'(bus.flush_pos), 32'd21);
    chk("t3_cnt", 32'(bus.brch_cnt), 32'd1);
    cycle(1, 1, 20, 2, 0, 0, 0, 0, 0);
    chk("t3_reuse_slot", 32'(dut.ent_q[1].idx), 32'd20);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 40);
    chk("t4_miss", 32'(bus.flush_miss), 32'd1);
    chk("t4_pos", 32'(bus.flush_pos), 32'd0);
    chk("t4_cnt", 32'(bus.brch_cnt), 32'd2);

    // Commit + mispredict + wrong-path lanes together.
    do_reset();
    cycle(1, 1, 3, 11, 0, 0, 0, 0, 0);
    cycle(1, 1, 7, 21, 0, 0, 0, 0, 0);
    cycle(1, 1, 9, 33, 0, 0, 0, 0, 0);
    cycle(4'hF, 4'hF, 50, 0, 0, 1, 3, 1, 9);
    chk("t5_cnt", 32'(bus.brch_cnt), 32'd1);
    chk("t5_flush_pos", 32'(bus.flush_pos), 32'd33);
    cycle(0, 0, 0, 0, 0, 1, 7, 1, 7);
    chk("t5_head_both", 32'(bus.brch_cnt), 32'd0);

    // Pointer wrap with back-to-back alloc/commit, then a wrong commit index.
    do_reset();
    for (int i = 0; i < 3 * NE; i++) cycle(1, 1, i, i + 1, 1, (i > 0) ? 1 : 0, i - 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 3 * NE - 1);
    chk("t6_wrap_pos", 32'(bus.flush_pos), 32'(3 * NE));
    cycle(1, 1, 60, 9, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 61, 0, 0);
`ifdef BRCH_TBL_ERR_CHK_EN
    chk("t6_cmt_err", 32'(bus.cmt_err), 32'd1);
`endif
    cycle(0, 0, 0, 0, 0, 1, 0, 0, 0);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        v  = int'($urandom_range(0, 15));
        b  = int'($urandom_range(0, 15));
        c  = ($urandom_range(0, 2) == 0) ? 1 : 0;
        ci = (mq.size() > 0 && $urandom_range(0, 7) != 0) ? mq[0].idx : int'($urandom_range(0, 63));
        m  = ($urandom_range(0, 5) == 0) ? 1 : 0;
        mi = (mq.size() > 0 && $urandom_range(0, 3) != 0) ?
             mq[$urandom_range(0, mq.size() - 1)].idx : int'($urandom_range(0, 63));
        cycle(v, b, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 15)), c, ci, m, mi);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
